disp_scan: RTL

Parametrised time-multiplexed display scanner for the VGA/board-display path, and the successor to the fixed 2-bit `dispselect` digit counter. It scans DIGITS common-anode digits at a programmable slot rate and drives the active-low anode strobes and the selected digit's segment pattern. It adds a per-digit blanking mask, an inter-digit guard (dead) time against ghosting, and an enable/hold.

---
 rtl/disp_scan.sv | 77 +++++++
 1 files changed

// File: rtl/disp_scan.sv
// Time-multiplexed display scanner: steps through DIGITS common-anode digits, one slot of DIV
// cycles each, with a dead time at the start of every slot, per-digit blanking and a scan enable.
module disp_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 100000,
    parameter int unsigned GUARD  = 2,
    parameter int unsigned SEG_W  = 8,
    parameter int unsigned IDX_W  = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [DIGITS-1:0]       BLANK_MASK,
    input  logic [DIGITS*SEG_W-1:0] SEG_IN,
    output logic [IDX_W-1:0]        D_OUT,
    output logic [DIGITS-1:0]       AN_OUT,
    output logic [SEG_W-1:0]        SEG_OUT,
    output logic                    TICK
);

    localparam int unsigned       CW      = $clog2(DIV);
    localparam logic [CW-1:0]     CNT_MAX = CW'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic                slot_end;
    logic                guard_ok;
    logic [DIGITS-1:0]   an_next;
    logic [SEG_W-1:0]    seg_sel;

    assign slot_end = (cnt == CNT_MAX);
    assign TICK     = EN && slot_end;

    // With no dead time every count value is past the guard.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (cnt >= CW'(GUARD));
        end
    endgenerate

    always_comb begin
        an_next = '1;
        seg_sel = SEG_IN[SEG_W-1:0];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (D_OUT == IDX_W'(i)) begin
                seg_sel = SEG_IN[i*SEG_W +: SEG_W];
                if (EN && guard_ok && !BLANK_MASK[i]) begin
                    an_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            D_OUT   <= '0;
            AN_OUT  <= '1;
            SEG_OUT <= '1;
        end else begin
            if (EN) begin
                if (slot_end) begin
                    cnt   <= '0;
                    // Explicit wrap keeps non-power-of-two digit counts in range.
                    D_OUT <= (D_OUT == IDX_MAX) ? '0 : D_OUT + IDX_W'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            AN_OUT  <= an_next;
            SEG_OUT <= seg_sel;
        end
    end

endmodule
